// File: rtl/sevensegment_pkg.sv
// rtl/sevensegment_pkg.sv - glyph constants and FSM state type for the seven-segment capture block
package sevensegment_pkg;

    // Segment patterns, bit0=a .. bit6=g, segment lit = 1
    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DWELL    = 2'd1,
        CAPTURED = 2'd2
    } state_t;

endpackage

// File: rtl/sevensegment_decode.sv
// rtl/sevensegment_decode.sv - combinational seven-segment pattern to hex nibble decoder
module sevensegment_decode
    import sevensegment_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_legal
);

    // Map each legal hex glyph to its nibble; anything else is nibble 0 and illegal
    always_comb begin
        o_nibble = 4'h0;
        o_legal  = 1'b1;
        case (i_seg)
            SEG_GLYPH_0: o_nibble = 4'h0;
            SEG_GLYPH_1: o_nibble = 4'h1;
            SEG_GLYPH_2: o_nibble = 4'h2;
            SEG_GLYPH_3: o_nibble = 4'h3;
            SEG_GLYPH_4: o_nibble = 4'h4;
            SEG_GLYPH_5: o_nibble = 4'h5;
            SEG_GLYPH_6: o_nibble = 4'h6;
            SEG_GLYPH_7: o_nibble = 4'h7;
            SEG_GLYPH_8: o_nibble = 4'h8;
            SEG_GLYPH_9: o_nibble = 4'h9;
            SEG_GLYPH_A: o_nibble = 4'hA;
            SEG_GLYPH_B: o_nibble = 4'hB;
            SEG_GLYPH_C: o_nibble = 4'hC;
            SEG_GLYPH_D: o_nibble = 4'hD;
            SEG_GLYPH_E: o_nibble = 4'hE;
            SEG_GLYPH_F: o_nibble = 4'hF;
            default:     o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevensegment_capture.sv
// rtl/sevensegment_capture.sv - multiplexed seven-segment bus reader assembling decoded digits into frames
module sevensegment_capture
    import sevensegment_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   out_value,
    output logic [DIGITS-1:0]     out_invalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int SMP_W = DIGITS + 7;
    // The sample that makes the dwell STABLE_CYCLES long arrives while the counter holds STABLE_CYCLES-2
    localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]          r_seg_s1, r_seg_s2;
    logic [DIGITS-1:0]   r_an_s1, r_an_s2;
    logic [SMP_W-1:0]    r_prev_sample;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    state_t              r_state, w_state_next;
    logic                w_capture;

    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_an;
    logic [SMP_W-1:0]    w_sample;
    logic                w_usable;
    logic                w_same;
    logic [3:0]          w_nibble;
    logic                w_legal;

    logic [4*DIGITS-1:0] r_frame, w_frame_next;
    logic [DIGITS-1:0]   r_frame_inv, w_inv_next;
    logic [DIGITS-1:0]   r_mask, w_mask_next;
    logic                w_complete;
    logic                w_accept;

    logic [4*DIGITS-1:0] r_out_value;
    logic [DIGITS-1:0]   r_out_invalid;
    logic                r_out_valid;
    logic                r_overrun;

    // Two-flop synchronizers for the asynchronous display lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_an_s1  <= '0;
            r_an_s2  <= '0;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
        end
    end

    assign w_seg    = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s2 : r_seg_s2;
    assign w_an     = (AN_ACTIVE_LOW != 0) ? ~r_an_s2 : r_an_s2;
    assign w_sample = {w_an, w_seg};
    assign w_usable = $onehot(w_an);
    assign w_same   = (w_sample == r_prev_sample);

    sevensegment_decode u_decode (
        .i_seg    (w_seg),
        .o_nibble (w_nibble),
        .o_legal  (w_legal)
    );

    // State, dwell counter and previous-sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_prev_sample <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_prev_sample <= w_sample;
        end
    end

    // Dwell tracking: capture once per stable dwell, counter saturates at CNT_MAX
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_usable) begin
                    w_state_next = DWELL;
                    w_cnt_next   = '0;
                end
            end
            DWELL: begin
                if (!w_usable) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (!w_same) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_CAPTURE) begin
                    w_capture    = 1'b1;
                    w_state_next = CAPTURED;
                    w_cnt_next   = CNT_MAX;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            CAPTURED: begin
                if (!w_usable) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (!w_same) begin
                    w_state_next = DWELL;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Merge the captured digit into the working frame at the selected index
    always_comb begin
        w_frame_next = r_frame;
        w_inv_next   = r_frame_inv;
        w_mask_next  = r_mask;
        if (w_capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_an[i]) begin
                    w_frame_next[4*i +: 4] = w_nibble;
                    w_inv_next[i]          = ~w_legal;
                    w_mask_next[i]         = 1'b1;
                end
            end
        end
    end

    assign w_complete = w_capture && (&w_mask_next);
    assign w_accept   = !r_out_valid || out_ready;

    // Working frame storage; the mask restarts as soon as a frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame     <= '0;
            r_frame_inv <= '0;
            r_mask      <= '0;
        end else begin
            r_frame     <= w_frame_next;
            r_frame_inv <= w_inv_next;
            r_mask      <= w_complete ? '0 : w_mask_next;
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_value   <= '0;
            r_out_invalid <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete && w_accept) begin
                r_out_value   <= w_frame_next;
                r_out_invalid <= w_inv_next;
                r_out_valid   <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_value   = r_out_value;
    assign out_invalid = r_out_invalid;
    assign out_valid   = r_out_valid;
    assign overrun     = r_overrun;

endmodule

// File: doc/sevensegment_capture.md
Name: sevensegment_capture

Overview:
Reader for a multiplexed seven-segment display bus. It monitors segment lines and digit (anode) selects driven by a scanning display controller, and decodes each stable segment pattern back to a hex nibble. It assembles one nibble per digit into a word and presents each completed frame on a valid/ready output. It serves on-chip self-check of display paths and capture of display output from external boards.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 16, consecutive identical synchronized samples required before a digit is captured (>=2)
SEG_ACTIVE_LOW, 0, 1: seg_in is inverted before decoding
AN_ACTIVE_LOW, 0, 1: an_in is inverted before decoding

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
seg_in  in  7  segment lines, bit0=a .. bit6=g, asynchronous to clk
an_in  in  DIGITS  digit selects, bit i = digit i, asynchronous to clk
out_value  out  4*DIGITS  captured frame, digit i in bits [4i+3:4i]
out_invalid  out  DIGITS  bit i set: digit i pattern was not a legal hex glyph
out_valid  out  1  frame available
out_ready  in  1  consumer accepts frame
overrun  out  1  one-cycle pulse: completed frame dropped due to backpressure

Behaviour:
- Reset: out_value=0, out_invalid=0, out_valid=0, overrun=0, FSM=IDLE, stability counter=0, captured-digit mask=0. Asserting rst mid-frame discards the partial frame.
- seg_in and an_in each pass through a 2-flop synchronizer, then polarity normalization. "Sample" means the normalized {an,seg}.
- Sample is usable only when an is one-hot. All-zero an or more than one bit set counts as not usable.
- FSM states:
  - IDLE: waits for a usable sample, then goes to DWELL with counter=0.
  - DWELL: a usable sample equal to the previous sample increments the counter. A changed usable sample resets the counter to 0. A non-usable sample goes to IDLE. When the counter reaches STABLE_CYCLES-1 with the sample still unchanged, the digit is captured and the FSM goes to CAPTURED.
  - CAPTURED: a changed usable sample goes to DWELL with counter=0. A non-usable sample goes to IDLE. Each stable dwell is captured exactly once.
- Capture: the pattern is decoded (a=bit0 .. g=bit6):
  - 0 0x3F, 1 0x06, 2 0x5B, 3 0x4F, 4 0x66, 5 0x6D, 6 0x7D, 7 0x07
  - 8 0x7F, 9 0x6F, A 0x77, b 0x7C, C 0x39, d 0x5E, E 0x79, F 0x71
  - Any other pattern decodes to nibble 0 and sets that digit's invalid bit.
  - The nibble and invalid bit go into the working frame at the selected index, and the mask bit is set. Re-capturing a digit before the frame completes overwrites its nibble and invalid bit.
- Frame complete occurs when the mask becomes all ones, counting the current capture. The mask clears in the same cycle.
  - If out_valid=0, or out_valid&&out_ready that cycle: out_value/out_invalid load the frame and out_valid=1 on the next cycle.
  - Otherwise the frame is dropped, outputs are unchanged, and overrun=1 for one cycle.
- Handshake: out_valid, once set, holds until out_valid&&out_ready. out_value and out_invalid are stable while out_valid=1. A transfer with no simultaneous completion clears out_valid next cycle.
- Latency: a capture happens STABLE_CYCLES+2 clk cycles after the input change (synchronizer plus dwell). out_valid asserts 1 cycle after the final capture.
- Counter width is clog2(STABLE_CYCLES). The counter saturates and never wraps.

Decomposition:
- Package sevensegment_pkg holds:
  - localparams SEG_GLYPH_0..SEG_GLYPH_F (7-bit)
  - FSM state enum {IDLE, DWELL, CAPTURED}
- Sub-module sevensegment_decode: combinational, 7-bit pattern -> 4-bit nibble + 1-bit legal flag.
- Synchronizer, FSM and frame assembly stay in the top module.

Test Plan:
- DIGITS=4, STABLE_CYCLES=4, out_ready=1. Scan an=0001/0x66, 0010/0x4F, 0100/0x5B, 1000/0x06, each held 8 cycles -> one out_valid pulse, out_value=16'h1234, out_invalid=0.
- Digit 0 pattern held only 3 synchronized cycles, then the full valid scan -> the short dwell is not captured; the frame reflects only the full-length dwells.
- Digit 2 shows 0x01 (segment a only) within the scan above -> out_value=16'h1034, out_invalid=4'b0100.
- out_ready=0, two complete scans -> first frame held, overrun pulses exactly once at the second completion. Raising out_ready then transfers the first frame once.
- an=0011 or an=0000 held 20 cycles between digits -> no capture, FSM in IDLE, the subsequent scan completes normally.
- rst pulsed after 2 digits captured, then a full scan -> all outputs 0 during reset, and the post-reset frame contains only post-reset digits. SEG_ACTIVE_LOW=1 with inverted seg_in gives an identical out_value.
